// File: rtl/vga_timing_gradient_if.sv
// rtl/vga_timing_gradient_if.sv - raster timing and gradient lookup signal bundle
interface vga_timing_gradient_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [6:0] grad_y;
    logic [1:0] grad_x;
    logic       grad_pixel;

    modport master (
        output hpos, vpos, hsync, vsync, display_on, grad_pixel,
        input  grad_y, grad_x
    );

    modport slave (
        input  hpos, vpos, hsync, vsync, display_on, grad_pixel,
        output grad_y, grad_x
    );
endinterface

// File: rtl/vga_timing_gradient.sv
// rtl/vga_timing_gradient.sv - VGA raster counters, registered syncs and Bayer dither lookup
module vga_timing_gradient #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vga_timing_gradient_if.master  bus
);
    localparam logic [9:0] H_LAST     = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);

    logic [9:0] hpos_q;
    logic [9:0] vpos_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       end_of_line;

    assign end_of_line = (hpos_q == H_LAST);

    // Syncs compare the pre-increment counters, so they trail hpos/vpos by one clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hpos_q  <= end_of_line ? '0 : hpos_q + 10'd1;
            if (end_of_line) begin
                vpos_q <= (vpos_q == V_LAST) ? '0 : vpos_q + 10'd1;
            end
            hsync_q <= ~((hpos_q >= H_SYNC_BEG) && (hpos_q <= H_SYNC_END));
            vsync_q <= ~((vpos_q >= V_SYNC_BEG) && (vpos_q <= V_SYNC_END));
        end
    end

    assign bus.hpos       = hpos_q;
    assign bus.vpos       = vpos_q;
    assign bus.hsync      = hsync_q;
    assign bus.vsync      = vsync_q;
    assign bus.display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

    logic [3:0] threshold;
    logic [4:0] limit;

    always_comb begin
        threshold = 4'd0;
        case ({bus.grad_y[1:0], bus.grad_x})
            4'h0: threshold = 4'd0;
            4'h1: threshold = 4'd8;
            4'h2: threshold = 4'd2;
            4'h3: threshold = 4'd10;
            4'h4: threshold = 4'd12;
            4'h5: threshold = 4'd4;
            4'h6: threshold = 4'd14;
            4'h7: threshold = 4'd6;
            4'h8: threshold = 4'd3;
            4'h9: threshold = 4'd11;
            4'hA: threshold = 4'd1;
            4'hB: threshold = 4'd9;
            4'hC: threshold = 4'd15;
            4'hD: threshold = 4'd7;
            4'hE: threshold = 4'd13;
            4'hF: threshold = 4'd5;
            default: threshold = 4'd0;
        endcase
    end

    // Level 0 yields limit 16, so every threshold passes and the band is solid.
    assign limit          = 5'd16 - {1'b0, bus.grad_y[6:3]};
    assign bus.grad_pixel = ({1'b0, threshold} < limit);
endmodule

// File: tb/tb_vga_timing_gradient.sv
// tb/tb_vga_timing_gradient.sv - scoreboard bench for full-size and shrunken raster instances
module tb_vga_timing_gradient;
    localparam int SHD = 16, SHF = 4, SHS = 8, SHB = 4;
    localparam int SVD = 12, SVF = 3, SVS = 2, SVB = 3;
    localparam int S_HT = SHD + SHF + SHS + SHB;
    localparam int S_VT = SVD + SVF + SVS + SVB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gradient_if big_bus ();
    vga_timing_gradient_if small_bus ();

    vga_timing_gradient dut_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (big_bus.master)
    );

    vga_timing_gradient #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (small_bus.master)
    );

    typedef struct {
        int h, v;     bit hs, vs, dn;
        int sh, sv;   bit shs, svs, sdn;
        bit g;        bit sweep;   int gy;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;
    longint n = 0;
    int   bayer [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int   band_ones [16];

    // Position of a raster after n active clocks since reset, from plain division.
    function automatic void raster(input longint cnt, input int hd, input int hf, input int hw, input int hb,
                                   input int vd, input int vf, input int vw, input int vb,
                                   output int h, output int v, output bit hs, output bit vs, output bit dn);
        int ht, vt, ph, pv;
        ht = hd + hf + hw + hb;
        vt = vd + vf + vw + vb;
        h  = int'(cnt % ht);
        v  = int'((cnt / ht) % vt);
        dn = (h < hd) && (v < vd);
        if (cnt == 0) begin
            hs = 1'b1;
            vs = 1'b1;
        end else begin
            ph = int'((cnt - 1) % ht);
            pv = int'(((cnt - 1) / ht) % vt);
            hs = !(ph >= hd + hf && ph < hd + hf + hw);
            vs = !(pv >= vd + vf && pv < vd + vf + vw);
        end
    endfunction

    task automatic step(input bit r, input int gy, input int gx, input bit sw);
        exp_t e;
        rst_n = r;
        big_bus.grad_y   = 7'(gy);
        big_bus.grad_x   = 2'(gx);
        small_bus.grad_y = 7'(gy);
        small_bus.grad_x = 2'(gx);
        if (!r) n = 0;
        else    n = n + 1;
        raster(n, 640, 16, 96, 48, 480, 10, 2, 33, e.h, e.v, e.hs, e.vs, e.dn);
        raster(n, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, e.sh, e.sv, e.shs, e.svs, e.sdn);
        e.g     = bayer[(gy % 4) * 4 + gx] < (16 - gy / 8);
        e.sweep = sw;
        e.gy    = gy;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_random(input int cycles, input int reset_odds);
        for (int i = 0; i < cycles; i++) begin
            step((reset_odds > 0 && $urandom_range(reset_odds - 1) == 0) ? 1'b0 : 1'b1,
                 int'($urandom_range(127)), int'($urandom_range(3)), 1'b0);
        end
    endtask

    // Monitor: per-cycle scoreboard plus line and frame aggregates.
    int lc = 0, dc = 0, hl = 0, fh = -1;
    int fc = 0, fdc = 0, vl = 0, fvh = -1, fvv = -1;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (big_bus.hpos != 10'(e.h) || big_bus.vpos != 10'(e.v) || big_bus.hsync != e.hs ||
                    big_bus.vsync != e.vs || big_bus.display_on != e.dn) begin
                    fails++;
                    $display("FAIL big_raster n=%0d: got h=%0d v=%0d hs=%0b vs=%0b dn=%0b, want h=%0d v=%0d hs=%0b vs=%0b dn=%0b",
                             n, big_bus.hpos, big_bus.vpos, big_bus.hsync, big_bus.vsync, big_bus.display_on,
                             e.h, e.v, e.hs, e.vs, e.dn);
                end
                tests++;
                if (small_bus.hpos != 10'(e.sh) || small_bus.vpos != 10'(e.sv) || small_bus.hsync != e.shs ||
                    small_bus.vsync != e.svs || small_bus.display_on != e.sdn) begin
                    fails++;
                    $display("FAIL small_raster: got h=%0d v=%0d hs=%0b vs=%0b dn=%0b, want h=%0d v=%0d hs=%0b vs=%0b dn=%0b",
                             small_bus.hpos, small_bus.vpos, small_bus.hsync, small_bus.vsync, small_bus.display_on,
                             e.sh, e.sv, e.shs, e.svs, e.sdn);
                end
                tests++;
                if (big_bus.grad_pixel != e.g || small_bus.grad_pixel != e.g) begin
                    fails++;
                    $display("FAIL grad_pixel y=%0d x=%0d: got %0b/%0b, want %0b",
                             big_bus.grad_y, big_bus.grad_x, big_bus.grad_pixel, small_bus.grad_pixel, e.g);
                end
                if (e.sweep) band_ones[e.gy / 8] += int'(big_bus.grad_pixel);

                if (big_bus.hpos == 10'd0) begin
                    if (lc == 800) begin
                        tests++;
                        if (dc != 640 || hl != 96 || fh != 657) begin
                            fails++;
                            $display("FAIL line_aggregate: got display=%0d hsync_low=%0d first_low_hpos=%0d, want 640 96 657",
                                     dc, hl, fh);
                        end
                    end
                    lc = 0; dc = 0; hl = 0; fh = -1;
                end
                lc++;
                dc += int'(big_bus.display_on);
                if (!big_bus.hsync) begin
                    if (hl == 0) fh = int'(big_bus.hpos);
                    hl++;
                end

                if (small_bus.hpos == 10'd0 && small_bus.vpos == 10'd0) begin
                    if (fc == S_HT * S_VT) begin
                        tests++;
                        if (fdc != SHD * SVD || vl != SVS * S_HT || fvv != SVD + SVF || fvh != 1) begin
                            fails++;
                            $display("FAIL frame_aggregate: got display=%0d vsync_low=%0d first_low=(v%0d,h%0d), want %0d %0d (v%0d,h1)",
                                     fdc, vl, fvv, fvh, SHD * SVD, SVS * S_HT, SVD + SVF);
                        end
                    end
                    fc = 0; fdc = 0; vl = 0; fvh = -1; fvv = -1;
                end
                fc++;
                fdc += int'(small_bus.display_on);
                if (!small_bus.vsync) begin
                    if (vl == 0) begin
                        fvh = int'(small_bus.hpos);
                        fvv = int'(small_bus.vpos);
                    end
                    vl++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) band_ones[i] = 0;
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 512; i++) step(1'b1, i / 4, i % 4, 1'b1);
        run_random(1800 - 512, 0);
        while (n < 2 * 800 + 300) step(1'b1, int'($urandom_range(127)), int'($urandom_range(3)), 1'b0);
        step(1'b0, 64, 0, 1'b0);
        run_random(1700, 0);
        run_random(3000, 1500);
        run_random(1700, 0);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        for (int l = 0; l < 16; l++) begin
            tests++;
            if (band_ones[l] != (16 - l) * 2) begin
                fails++;
                $display("FAIL grad_band L=%0d: got %0d ones, want %0d", l, band_ones[l], (16 - l) * 2);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
